axi_rd_arbiter: RTL

- Shares the single AXI AR/R read channel between the instruction-fetch requester (IFU) and the load requester (LSU).
- Grants one request per slot and drives a registered, stable AR beat.
- Tracks one outstanding read per requester and routes R beats back by ID.
- Discards fetch responses that the IFU cancelled. It sits between the IFU/LSU request ports and the AXI master read channels of the core's bus interface.

---
 rtl/axi_rd_arbiter_if.sv | 64 ++++++
 rtl/axi_rd_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle between the IFU/LSU request ports, the read arbiter and the
// AXI AR/R read channels. The master modport is the arbiter's view (it owns
// the AXI master read channel); the slave modport is the surrounding view
// (requesters plus the AXI slave side).
//
// Handshake rules:
//   AR: arvalid/araddr/arid are held stable from the cycle arvalid rises until
//       the cycle arvalid & arready are both 1; the beat transfers on that edge.
//   R : rready is constantly 1, so every cycle with rvalid=1 is a transfer.
//   Requesters hold *_req and *_addr until *_addr_ok=1 in the same cycle.
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_cancel;
    logic              ifu_addr_ok;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_rerr;

    logic              lsu_req;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_addr_ok;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_rerr;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        input  ifu_req, ifu_addr, ifu_cancel,
        output ifu_addr_ok, ifu_rvalid, ifu_rdata, ifu_rerr,
        input  lsu_req, lsu_addr,
        output lsu_addr_ok, lsu_rvalid, lsu_rdata, lsu_rerr,
        output arid, araddr, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output ifu_req, ifu_addr, ifu_cancel,
        input  ifu_addr_ok, ifu_rvalid, ifu_rdata, ifu_rerr,
        output lsu_req, lsu_addr,
        input  lsu_addr_ok, lsu_rvalid, lsu_rdata, lsu_rerr,
        input  arid, araddr, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R channel between instruction fetch
// (IFU) and loads (LSU). One read outstanding per requester, round-robin on
// ties, registered AR beat, R beats routed back by ID, and cancelled fetch
// responses swallowed.
module axi_rd_arbiter #(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] IFU_ID = '0,
    parameter logic [ID_W-1:0] LSU_ID = {{(ID_W-1){1'b0}}, 1'b1}
) (
    input  logic               aclk,
    input  logic               aresetn,
    axi_rd_arbiter_if.master   bus
);

    // AR beat register; ar_busy_q is arvalid itself
    logic              ar_busy_q, ar_busy_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [ID_W-1:0]   arid_q,    arid_d;
    // per-requester outstanding flags and the fetch-drop flag
    logic              ifu_out_q,  ifu_out_d;
    logic              lsu_out_q,  lsu_out_d;
    logic              ifu_drop_q, ifu_drop_d;
    // 1 = LSU won the most recent grant, 0 = IFU
    logic              last_lsu_q, last_lsu_d;

    logic slot_free;
    logic ifu_elig, lsu_elig;
    logic ifu_win,  lsu_win;
    logic beat_done;
    logic ifu_hit,  lsu_hit;
    logic ifu_pulse;

    // The slot frees in the same cycle the pending beat handshakes, so
    // back-to-back accepts need no bubble.
    assign slot_free = ~ar_busy_q | bus.arready;
    assign ifu_elig  = bus.ifu_req & ~ifu_out_q;
    assign lsu_elig  = bus.lsu_req & ~lsu_out_q;
    // Gated by aresetn so no accept is signalled while reset is asserted.
    assign lsu_win   = aresetn & slot_free & lsu_elig & (~ifu_elig | ~last_lsu_q);
    assign ifu_win   = aresetn & slot_free & ifu_elig & (~lsu_elig |  last_lsu_q);

    assign beat_done = bus.rvalid & bus.rlast;
    assign ifu_hit   = beat_done & (bus.rid == IFU_ID) & ifu_out_q;
    assign lsu_hit   = beat_done & (bus.rid == LSU_ID) & lsu_out_q;
    // A cancel arriving with the response kills that response directly.
    assign ifu_pulse = ifu_hit & ~ifu_drop_q & ~bus.ifu_cancel;

    assign bus.ifu_addr_ok = ifu_win;
    assign bus.lsu_addr_ok = lsu_win;
    assign bus.ifu_rvalid  = ifu_pulse;
    assign bus.ifu_rdata   = ifu_pulse ? bus.rdata : {DATA_W{1'b0}};
    assign bus.ifu_rerr    = ifu_pulse & (|bus.rresp);
    assign bus.lsu_rvalid  = lsu_hit;
    assign bus.lsu_rdata   = lsu_hit ? bus.rdata : {DATA_W{1'b0}};
    assign bus.lsu_rerr    = lsu_hit & (|bus.rresp);
    assign bus.arvalid     = ar_busy_q;
    assign bus.araddr      = araddr_q;
    assign bus.arid        = arid_q;
    assign bus.rready      = 1'b1;

    // Next-state: AR slot load/release, outstanding tracking, drop, round-robin
    always_comb begin
        ar_busy_d  = ar_busy_q;
        araddr_d   = araddr_q;
        arid_d     = arid_q;
        ifu_out_d  = ifu_out_q;
        lsu_out_d  = lsu_out_q;
        ifu_drop_d = ifu_drop_q;
        last_lsu_d = last_lsu_q;

        if (lsu_win) begin
            ar_busy_d  = 1'b1;
            araddr_d   = bus.lsu_addr;
            arid_d     = LSU_ID;
            last_lsu_d = 1'b1;
        end else if (ifu_win) begin
            ar_busy_d  = 1'b1;
            araddr_d   = bus.ifu_addr;
            arid_d     = IFU_ID;
            last_lsu_d = 1'b0;
        end else if (ar_busy_q & bus.arready) begin
            ar_busy_d  = 1'b0;
        end

        // Accept and response for one requester are mutually exclusive
        // because accept needs *_out clear and a response needs it set.
        if (ifu_win) begin
            ifu_out_d = 1'b1;
        end else if (ifu_hit) begin
            ifu_out_d = 1'b0;
        end
        if (lsu_win) begin
            lsu_out_d = 1'b1;
        end else if (lsu_hit) begin
            lsu_out_d = 1'b0;
        end

        if (ifu_hit) begin
            ifu_drop_d = 1'b0;
        end else if (bus.ifu_cancel & (ifu_out_q | ifu_win)) begin
            ifu_drop_d = 1'b1;
        end
    end

    // State registers; reset abandons every in-flight read
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_busy_q  <= 1'b0;
            araddr_q   <= '0;
            arid_q     <= '0;
            ifu_out_q  <= 1'b0;
            lsu_out_q  <= 1'b0;
            ifu_drop_q <= 1'b0;
            last_lsu_q <= 1'b0;
        end else begin
            ar_busy_q  <= ar_busy_d;
            araddr_q   <= araddr_d;
            arid_q     <= arid_d;
            ifu_out_q  <= ifu_out_d;
            lsu_out_q  <= lsu_out_d;
            ifu_drop_q <= ifu_drop_d;
            last_lsu_q <= last_lsu_d;
        end
    end

endmodule
